// File: rtl/arbitro_rr4.sv
// arbitro_rr4: 4-input round-robin arbiter with a registered valid/ready output channel.
// The winner's word is captured into y, the requester gets a one-cycle ack and the
// priority pointer moves past the winner so every requester is served in turn.
module arbitro_rr4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [7:0]       grant_cnt
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 2;
    localparam int unsigned CW   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     sel_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic [WIDTH-1:0]  y_nxt;
    logic              y_valid_nxt;
    logic [CW-1:0]     cnt_nxt;

    logic [NREQ-1:0]   ereq;
    logic              win_found;
    logic [PW-1:0]     win;
    logic [WIDTH-1:0]  win_data;

    // Rotating priority scan of the effective requests starting at ptr.
    always_comb begin
        ereq      = req & ~ack;
        win_found = 1'b0;
        win       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && ereq[ptr + PW'(k)]) begin
                win_found = 1'b1;
                win       = ptr + PW'(k);
            end
        end
    end

    // Output mux driven by the current winner.
    always_comb begin
        case (win)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            2'd2:    win_data = data2;
            default: win_data = data3;
        endcase
    end

    // Next-state and next-output logic; a capture refills y in the same cycle it drains.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        ack_nxt     = '0;
        y_nxt       = y;
        y_valid_nxt = y_valid;
        cnt_nxt     = grant_cnt;

        case (state)
            IDLE: begin
                if (win_found) begin
                    y_nxt       = win_data;
                    sel_nxt     = win;
                    ack_nxt     = NREQ'(1) << win;
                    y_valid_nxt = 1'b1;
                    ptr_nxt     = win + PW'(1);
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (y_ready) begin
                    cnt_nxt = grant_cnt + CW'(1);
                    if (win_found) begin
                        y_nxt       = win_data;
                        sel_nxt     = win;
                        ack_nxt     = NREQ'(1) << win;
                        y_valid_nxt = 1'b1;
                        ptr_nxt     = win + PW'(1);
                        state_nxt   = HOLD;
                    end else begin
                        y_valid_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                y_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            ack       <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            grant_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            ack       <= ack_nxt;
            y         <= y_nxt;
            y_valid   <= y_valid_nxt;
            grant_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_arbitro_rr4.sv
// Bench for arbitro_rr4: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_arbitro_rr4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d [4];
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [7:0] grant_cnt;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state
    int         m_ptr;
    int         m_sel;
    int         m_cnt;
    logic [7:0] m_y;
    logic [3:0] m_ack;
    bit         m_valid;

    arbitro_rr4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (d[0]),
        .data1     (d[1]),
        .data2     (d[2]),
        .data3     (d[3]),
        .ack       (ack),
        .sel       (sel),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the output slot accepts a new word when empty or being drained this cycle;
    // the winner is the first effectively-requesting index at or after the pointer.
    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0; m_sel = 0; m_cnt = 0; m_y = 8'h00; m_ack = 4'b0000; m_valid = 0;
        end else begin
            logic [3:0] eff;
            int w;
            bit delivered, can_take;
            eff = req & ~m_ack;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && eff[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            delivered = m_valid && (y_ready === 1'b1);
            can_take  = !m_valid || delivered;
            if (delivered) m_cnt = (m_cnt + 1) % 256;
            if (can_take && w >= 0) begin
                m_y     = d[w];
                m_sel   = w;
                m_ack   = 4'(1 << w);
                m_valid = 1;
                m_ptr   = (w + 1) % 4;
            end else begin
                m_ack = 4'b0000;
                if (delivered) m_valid = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("y",         32'(y),         32'(m_y));
            chk("y_valid",   32'(y_valid),   32'(m_valid));
            chk("ack",       32'(ack),       32'(m_ack));
            chk("sel",       32'(sel),       32'(m_sel));
            chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        end
    end

    initial begin
        rst = 1'b1; req = 4'b1111; y_ready = 1'b0;
        d[0] = 8'h00; d[1] = 8'h01; d[2] = 8'h02; d[3] = 8'h03;

        // Reset with all requests raised
        tick();
        started = 1'b1;
        tick();
        chk("rst_y",       32'(y),         32'h00);
        chk("rst_y_valid", 32'(y_valid),   32'h0);
        chk("rst_ack",     32'(ack),       32'h0);
        chk("rst_sel",     32'(sel),       32'h0);
        chk("rst_cnt",     32'(grant_cnt), 32'h0);
        rst = 1'b0;
        tick();
        chk("first_grant_ack", 32'(ack), 32'b0001);
        chk("first_grant_y",   32'(y),   32'h00);
        req = 4'b0000; y_ready = 1'b1;
        tick();
        chk("first_drain_valid", 32'(y_valid), 32'h0);

        // Single request from requester 2
        req = 4'b0100;
        tick();
        chk("single_ack", 32'(ack), 32'b0100);
        chk("single_y",   32'(y),   32'h02);
        chk("single_sel", 32'(sel), 32'd2);
        req = 4'b0000;
        tick();
        chk("single_drop_valid", 32'(y_valid),   32'h0);
        chk("single_cnt",        32'(grant_cnt), 32'd2);

        // Full round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; y_ready = 1'b1;
        tick(); chk("rr0_y", 32'(y), 32'h00); chk("rr0_ack", 32'(ack), 32'b0001);
        tick(); chk("rr1_y", 32'(y), 32'h01); chk("rr1_ack", 32'(ack), 32'b0010);
        tick(); chk("rr2_y", 32'(y), 32'h02); chk("rr2_ack", 32'(ack), 32'b0100);
        tick(); chk("rr3_y", 32'(y), 32'h03); chk("rr3_ack", 32'(ack), 32'b1000);
        tick(); chk("rr4_y", 32'(y), 32'h00); chk("rr4_ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        tick();
        chk("rr_cnt",   32'(grant_cnt), 32'd5);
        chk("rr_valid", 32'(y_valid),   32'h0);

        // Backpressure: one capture, held stable while y_ready is low
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0011; y_ready = 1'b0;
        tick();
        chk("bp_first_ack", 32'(ack), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_ack",   32'(ack),     32'b0000);
            chk("bp_hold_y",     32'(y),       32'h00);
            chk("bp_hold_sel",   32'(sel),     32'd0);
            chk("bp_hold_valid", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        tick();
        chk("bp_release_y",   32'(y),   32'h01);
        chk("bp_release_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        tick();
        chk("bp_cnt", 32'(grant_cnt), 32'd2);

        // Pointer fairness: after serving 3, requester 0 goes before 3
        req = 4'b1000;
        tick();
        chk("fair_serve3", 32'(ack), 32'b1000);
        req = 4'b1001;
        tick();
        chk("fair_ack0", 32'(ack), 32'b0001);
        chk("fair_y0",   32'(y),   32'h00);
        tick();
        chk("fair_ack3", 32'(ack), 32'b1000);
        req = 4'b0000;
        tick();

        // Counter wrap after 256 deliveries
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; y_ready = 1'b1;
        d[0] = 8'hA5; d[1] = 8'h5A; d[2] = 8'hFF; d[3] = 8'h81;
        tick();
        for (int i = 0; i < 255; i++) tick();
        chk("cnt_255", 32'(grant_cnt), 32'd255);
        tick();
        chk("cnt_wrap",       32'(grant_cnt), 32'd0);
        chk("cnt_wrap_valid", 32'(y_valid),   32'h1);

        // Reset during HOLD with backpressure
        y_ready = 1'b0;
        tick();
        chk("mid_hold_valid", 32'(y_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(y_valid), 32'h0);
        chk("mid_rst_ack",   32'(ack),     32'h0);
        chk("mid_rst_cnt",   32'(grant_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_ptr0_ack", 32'(ack), 32'b0001);
        chk("mid_rst_ptr0_y",   32'(y),   32'hA5);
        req = 4'b0000; y_ready = 1'b1;
        tick();
        tick();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_rr4.md
# arbitro_rr4

Round-robin arbiter and output scheduler for the 4-input, 8-bit multiplexer datapath. Four requesters present a word on `data0`..`data3` and raise `req[i]`. The block grants one requester at a time and drives the mux select. It registers the chosen word into a single output channel with a valid/ready handshake and acknowledges the served requester. It sits between the requesters and the shared downstream consumer.

## Interface
- `WIDTH`, default 8: width of every data word.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  4: request vector; bit i belongs to `data<i>`.
- `data0`, `data1`, `data2`, `data3`  in  WIDTH each: requester words.
- `ack`  out  4: one-hot, one-cycle pulse marking the requester whose word was captured.
- `sel`  out  2: index of the most recent grant, which is the mux select.
- `y`  out  WIDTH: registered output word.
- `y_valid`  out  1: `y` holds an undelivered word.
- `y_ready`  in  1: consumer accepts `y` in any cycle where `y_valid && y_ready`.
- `grant_cnt`  out  8: total words delivered, modulo 256.

## Operation
- Reset values:
  - `y`=0, `y_valid`=0, `ack`=0, `sel`=0, `grant_cnt`=0.
  - Internal priority pointer `ptr`=0, so requester 0 has highest priority first.
  - FSM in IDLE.
- Effective requests: `ereq = req & ~ack`. A requester whose `ack` bit is high in the current cycle is never granted in that cycle. This prevents double capture while the requester drops `req`.
- Arbitration (combinational):
  - Scan `ereq` starting at `ptr`, then `ptr+1`, …, wrapping 3→0.
  - The first set bit is the winner `w`.
  - No set bit means no grant.
- FSM has two states, IDLE and HOLD.
  - **IDLE**
    - If a winner exists: at the edge, `y<=data<w>`, `sel<=w`, `ack<=onehot(w)`, `y_valid<=1`, `ptr<=(w+1) mod 4`, go to HOLD.
    - Otherwise stay in IDLE with `ack<=0`.
  - **HOLD**
    - While `y_ready`=0: `y`, `sel`, `y_valid` stay stable, `ack<=0`, no grant.
    - When `y_ready`=1, the word is delivered and `grant_cnt` increments. In the same cycle:
      - If a winner exists: capture the new word exactly as IDLE does and stay in HOLD (back-to-back transfer).
      - Otherwise `y_valid<=0` and go to IDLE. `y` and `sel` keep their last value.
- Requester rules:
  - Hold `req` and `data<i>` stable until `ack[i]` is seen.
  - Keeping `req` high after `ack[i]` requests another word. That requester is now lowest priority.
- `grant_cnt` wraps 255→0 with no flag.
- `ptr` wraps 3→0.
- `rst` asserted mid-transfer: the pending word is dropped, no `ack` is issued, and all reset values apply at the next edge.

## Timing
- Grant latency: `req[i]` seen in IDLE during cycle k gives `ack[i]`, `y`, `y_valid`=1 and `sel` visible in cycle k+1.
- `ack` is registered and is high for exactly one cycle per captured word.
- Throughput: one word per cycle while `y_ready`=1 and requests are pending. There is no bubble between words in HOLD.
- Deassert of `y_valid`: the edge after the last accepted handshake when no request is pending.
- `grant_cnt` updates at the edge ending the handshake cycle and is visible the following cycle.
- `y_ready` is ignored while `y_valid`=0.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req`=4'b1111 → `y`=0, `y_valid`=0, `ack`=0, `sel`=0, `grant_cnt`=0; the first grant after release goes to requester 0.
- **Single request:** `data2`=8'h02, `req`=4'b0100, `y_ready`=1 → next cycle `ack`=4'b0100, `y`=8'h02, `sel`=2'b10; `y_valid` drops one cycle later; `grant_cnt`=1.
- **Full round-robin:** `data0..3`=8'h00/01/02/03, `req`=4'b1111 held, `y_ready`=1 → `y` sequence 00,01,02,03,00 on consecutive cycles, with `ack` rotating 0001,0010,0100,1000,0001.
- **Backpressure:** `req`=4'b0011, `y_ready`=0 for 5 cycles → `y`=8'h00, `sel`=0 held, only one `ack` pulse; raise `y_ready` → `y`=8'h01 next cycle.
- **Pointer fairness:** after serving requester 3, assert `req`=4'b1001 → requester 0 granted before 3.
- **Counter wrap and mid-reset:** 256 deliveries → `grant_cnt`=0; then `rst` during HOLD with `y_ready`=0 → `y_valid`=0, no `ack`, `ptr`=0.
